// File: rtl/irrigacao_multizona.sv
// Multi-zone irrigation sequencer: round-robin zone service, fill -> drip|spray -> clean, BCD countdown.
// Optional agrochemical injector built when AGRO_DEFENSIVO_EN is defined.
module irrigacao_multizona #(
    parameter int unsigned ZONES    = 4,
    parameter int unsigned TICK_DIV = 50_000_000,
    parameter logic [7:0]  T_ENCH   = 8'h10,
    parameter logic [7:0]  T_GOT    = 8'h30,
    parameter logic [7:0]  T_ASP    = 8'h20,
    parameter logic [7:0]  T_LIMP   = 8'h05,
    localparam int unsigned ZW      = (ZONES > 1) ? $clog2(ZONES) : 1
) (
    input  logic             clk1,
    input  logic             reset_n,
    input  logic [ZONES-1:0] zona_req,
    input  logic [ZONES-1:0] zona_aspersao,
    input  logic             pausa,
    input  logic             agroDefensivo,
    output logic             bomba,
    output logic [ZONES-1:0] valvula,
    output logic [3:0]       estado,
    output logic [ZW-1:0]    zona_ativa,
    output logic [3:0]       unidade,
    output logic [3:0]       dezena,
    output logic             ciclo_fim,
    output logic             saidaAgroDefensivo
);

    localparam int unsigned PW = $clog2(TICK_DIV);

    // One-hot encoding doubles as the estado display vector.
    typedef enum logic [3:0] {
        IDLE = 4'b0000,
        ENCH = 4'b0001,
        GOT  = 4'b0010,
        ASP  = 4'b0100,
        LIMP = 4'b1000
    } state_t;

    state_t         state, state_n;
    logic [PW-1:0]  presc, presc_n;
    logic [3:0]     dez_n, uni_n;
    logic [ZW-1:0]  zona_n;
    logic           modo, modo_n;
    logic [ZW-1:0]  ptr, ptr_n;
    logic           fim_n;
    logic           tick;
    logic           found;
    logic [ZW-1:0]  sel;
    logic [ZW-1:0]  ptr_next;

    function automatic logic [7:0] dur(input logic [7:0] d);
        return (d == 8'h00) ? 8'h01 : d;
    endfunction

    // First pending request at or after ptr, wrapping at ZONES-1.
    always_comb begin
        int unsigned idx;
        logic [ZW-1:0] cand;
        found = 1'b0;
        sel   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < ZONES; i++) begin
            idx = 32'(ptr) + i;
            if (idx >= ZONES) begin
                idx = idx - ZONES;
            end
            cand = ZW'(idx);
            if (!found && zona_req[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    assign ptr_next = (zona_ativa == ZW'(ZONES - 1)) ? '0 : zona_ativa + ZW'(1);
    assign tick     = (state != IDLE) && !pausa && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            presc      <= '0;
            dezena     <= '0;
            unidade    <= '0;
            zona_ativa <= '0;
            modo       <= 1'b0;
            ptr        <= '0;
            ciclo_fim  <= 1'b0;
        end else begin
            state      <= state_n;
            presc      <= presc_n;
            dezena     <= dez_n;
            unidade    <= uni_n;
            zona_ativa <= zona_n;
            modo       <= modo_n;
            ptr        <= ptr_n;
            ciclo_fim  <= fim_n;
        end
    end

    always_comb begin
        state_n = state;
        presc_n = presc;
        dez_n   = dezena;
        uni_n   = unidade;
        zona_n  = zona_ativa;
        modo_n  = modo;
        ptr_n   = ptr;
        fim_n   = 1'b0;

        if ((state != IDLE) && !pausa) begin
            presc_n = tick ? '0 : presc + PW'(1);
        end

        case (state)
            IDLE: begin
                if (found && !pausa) begin
                    state_n        = ENCH;
                    zona_n         = sel;
                    modo_n         = zona_aspersao[sel];
                    presc_n        = '0;
                    {dez_n, uni_n} = dur(T_ENCH);
                end
            end
            default: begin
                if (tick) begin
                    if ({dezena, unidade} == 8'h01) begin
                        // Last second of the phase: hand over to the next phase in one edge.
                        case (state)
                            ENCH: begin
                                if (modo) begin
                                    state_n        = ASP;
                                    {dez_n, uni_n} = dur(T_ASP);
                                end else begin
                                    state_n        = GOT;
                                    {dez_n, uni_n} = dur(T_GOT);
                                end
                            end
                            ASP: begin
                                state_n        = LIMP;
                                {dez_n, uni_n} = dur(T_LIMP);
                            end
                            default: begin
                                state_n        = IDLE;
                                {dez_n, uni_n} = 8'h00;
                                ptr_n          = ptr_next;
                                fim_n          = 1'b1;
                            end
                        endcase
                    end else if (unidade == 4'd0) begin
                        uni_n = 4'd9;
                        dez_n = dezena - 4'd1;
                    end else begin
                        uni_n = unidade - 4'd1;
                    end
                end
            end
        endcase
    end

    assign bomba   = (state == ENCH) && !pausa;
    assign valvula = (((state == GOT) || (state == ASP)) && !pausa)
                     ? (ZONES'(1) << zona_ativa) : '0;
    assign estado  = state;

`ifdef AGRO_DEFENSIVO_EN
    logic [2:0] agro_sync;
    logic       armado;

    // Two synchronising flops plus one for rising-edge detection.
    always_ff @(posedge clk1 or negedge reset_n) begin
        if (!reset_n) begin
            agro_sync <= '0;
            armado    <= 1'b0;
        end else begin
            agro_sync <= {agro_sync[1:0], agroDefensivo};
            if (agro_sync[1] && !agro_sync[2]) begin
                armado <= !armado;
            end
        end
    end

    assign saidaAgroDefensivo = armado && (state == ASP) && !pausa;
`else
    logic unused_agro;
    assign unused_agro        = agroDefensivo;
    assign saidaAgroDefensivo = 1'b0;
`endif

endmodule

// File: tb/tb_irrigacao_multizona.sv
// Directed bench for irrigacao_multizona: drip, pause, spray/agro, reset abort, round-robin, BCD borrow.
module tb_irrigacao_multizona;

`ifdef AGRO_DEFENSIVO_EN
    localparam logic AGRO = 1'b1;
`else
    localparam logic AGRO = 1'b0;
`endif

    logic       clk1 = 1'b0;
    logic       reset_n;
    logic [3:0] zona_req, zona_aspersao;
    logic       pausa, agroDefensivo;
    logic       bomba, ciclo_fim, saidaAgroDefensivo;
    logic [3:0] valvula, estado, unidade, dezena;
    logic [1:0] zona_ativa;

    logic [1:0] req_b;
    logic       bomba_b, ciclo_fim_b, saida_b;
    logic [1:0] valvula_b;
    logic [3:0] estado_b, unidade_b, dezena_b;
    logic [0:0] zona_ativa_b;

    int errors = 0;
    int checks = 0;

    always #5 clk1 = ~clk1;

    irrigacao_multizona #(
        .ZONES(4), .TICK_DIV(4), .T_ENCH(8'h02), .T_GOT(8'h03), .T_ASP(8'h02), .T_LIMP(8'h01)
    ) dut (
        .clk1(clk1), .reset_n(reset_n), .zona_req(zona_req), .zona_aspersao(zona_aspersao),
        .pausa(pausa), .agroDefensivo(agroDefensivo), .bomba(bomba), .valvula(valvula),
        .estado(estado), .zona_ativa(zona_ativa), .unidade(unidade), .dezena(dezena),
        .ciclo_fim(ciclo_fim), .saidaAgroDefensivo(saidaAgroDefensivo)
    );

    irrigacao_multizona #(
        .ZONES(2), .TICK_DIV(2), .T_ENCH(8'h00), .T_GOT(8'h10), .T_ASP(8'h02), .T_LIMP(8'h01)
    ) dut_b (
        .clk1(clk1), .reset_n(reset_n), .zona_req(req_b), .zona_aspersao(2'b00),
        .pausa(1'b0), .agroDefensivo(1'b0), .bomba(bomba_b), .valvula(valvula_b),
        .estado(estado_b), .zona_ativa(zona_ativa_b), .unidade(unidade_b), .dezena(dezena_b),
        .ciclo_fim(ciclo_fim_b), .saidaAgroDefensivo(saida_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk1);
        #1;
    endtask

    initial begin
        reset_n = 1'b0; zona_req = '0; zona_aspersao = '0; pausa = 1'b0; agroDefensivo = 1'b0;
        req_b = '0;
        cyc(3);
        check("rst_estado", 32'(estado), 32'h0);
        check("rst_bomba", 32'(bomba), 32'h0);
        check("rst_valvula", 32'(valvula), 32'h0);
        check("rst_digits", 32'({dezena, unidade}), 32'h00);
        check("rst_zona", 32'(zona_ativa), 32'h0);
        check("rst_fim", 32'(ciclo_fim), 32'h0);
        check("rst_agro", 32'(saidaAgroDefensivo), 32'h0);
        reset_n = 1'b1;
        cyc(1);

        // Drip cycle on zone 2
        zona_req = 4'b0100; zona_aspersao = 4'b0000;
        cyc(1);
        check("drip_ench_estado", 32'(estado), 32'h1);
        check("drip_ench_bomba", 32'(bomba), 32'h1);
        check("drip_ench_digits", 32'({dezena, unidade}), 32'h02);
        check("drip_zona", 32'(zona_ativa), 32'h2);
        zona_req = 4'b0000;
        cyc(3);
        check("drip_ench_d3", 32'({dezena, unidade}), 32'h02);
        cyc(1);
        check("drip_ench_d4", 32'({dezena, unidade}), 32'h01);
        check("drip_ench_bomba4", 32'(bomba), 32'h1);
        cyc(3);
        check("drip_ench_last", 32'(estado), 32'h1);
        cyc(1);
        check("drip_got_estado", 32'(estado), 32'h2);
        check("drip_got_bomba", 32'(bomba), 32'h0);
        check("drip_got_valvula", 32'(valvula), 32'h4);
        check("drip_got_digits", 32'({dezena, unidade}), 32'h03);
        cyc(11);
        check("drip_got_last", 32'(estado), 32'h2);
        check("drip_got_last_d", 32'({dezena, unidade}), 32'h01);
        cyc(1);
        check("drip_idle_estado", 32'(estado), 32'h0);
        check("drip_idle_fim", 32'(ciclo_fim), 32'h1);
        check("drip_idle_zona", 32'(zona_ativa), 32'h2);
        check("drip_idle_digits", 32'({dezena, unidade}), 32'h00);
        check("drip_idle_valvula", 32'(valvula), 32'h0);
        cyc(1);
        check("drip_fim_pulse", 32'(ciclo_fim), 32'h0);

        // Pause mid-GOT (ptr=3 wraps to zone 2)
        zona_req = 4'b0100;
        cyc(1);
        check("pause_zona", 32'(zona_ativa), 32'h2);
        zona_req = 4'b0000;
        cyc(8);
        check("pause_got", 32'(estado), 32'h2);
        cyc(5);
        check("pause_pre_digits", 32'({dezena, unidade}), 32'h02);
        pausa = 1'b1;
        #1;
        check("pause_valvula_off", 32'(valvula), 32'h0);
        check("pause_estado_vis", 32'(estado), 32'h2);
        cyc(7);
        check("pause_digits_frozen", 32'({dezena, unidade}), 32'h02);
        check("pause_estado_hold", 32'(estado), 32'h2);
        check("pause_valvula_hold", 32'(valvula), 32'h0);
        pausa = 1'b0;
        #1;
        check("pause_valvula_back", 32'(valvula), 32'h4);
        cyc(6);
        check("pause_tail_estado", 32'(estado), 32'h2);
        check("pause_tail_digits", 32'({dezena, unidade}), 32'h01);
        cyc(1);
        check("pause_end_estado", 32'(estado), 32'h0);
        check("pause_end_fim", 32'(ciclo_fim), 32'h1);

        // Spray cycle on zone 1 with agrochemical armed
        agroDefensivo = 1'b1;
        cyc(1);
        agroDefensivo = 1'b0;
        cyc(3);
        zona_req = 4'b0010; zona_aspersao = 4'b0010;
        cyc(1);
        check("spray_zona", 32'(zona_ativa), 32'h1);
        check("spray_ench", 32'(estado), 32'h1);
        check("spray_ench_agro", 32'(saidaAgroDefensivo), 32'h0);
        zona_req = 4'b0000; zona_aspersao = 4'b0000;
        cyc(8);
        check("spray_asp_estado", 32'(estado), 32'h4);
        check("spray_asp_valvula", 32'(valvula), 32'h2);
        check("spray_asp_bomba", 32'(bomba), 32'h0);
        check("spray_asp_agro", 32'(saidaAgroDefensivo), 32'(AGRO));
        check("spray_asp_digits", 32'({dezena, unidade}), 32'h02);
        cyc(7);
        check("spray_asp_last", 32'(estado), 32'h4);
        check("spray_asp_agro_last", 32'(saidaAgroDefensivo), 32'(AGRO));
        cyc(1);
        check("spray_limp_estado", 32'(estado), 32'h8);
        check("spray_limp_valvula", 32'(valvula), 32'h0);
        check("spray_limp_agro", 32'(saidaAgroDefensivo), 32'h0);
        check("spray_limp_digits", 32'({dezena, unidade}), 32'h01);
        cyc(3);
        check("spray_limp_last", 32'(estado), 32'h8);
        cyc(1);
        check("spray_idle", 32'(estado), 32'h0);
        check("spray_fim", 32'(ciclo_fim), 32'h1);

        // Reset mid-ASP (ptr=2 selects zone 3)
        zona_req = 4'b1011; zona_aspersao = 4'b1111;
        cyc(1);
        check("abort_zona", 32'(zona_ativa), 32'h3);
        cyc(8);
        check("abort_asp", 32'(estado), 32'h4);
        check("abort_asp_agro", 32'(saidaAgroDefensivo), 32'(AGRO));
        cyc(2);
        reset_n = 1'b0;
        #1;
        check("abort_estado", 32'(estado), 32'h0);
        check("abort_valvula", 32'(valvula), 32'h0);
        check("abort_bomba", 32'(bomba), 32'h0);
        check("abort_agro", 32'(saidaAgroDefensivo), 32'h0);
        check("abort_digits", 32'({dezena, unidade}), 32'h00);
        check("abort_zona0", 32'(zona_ativa), 32'h0);
        zona_aspersao = 4'b0000;
        cyc(2);
        reset_n = 1'b1;

        // Round-robin with 4'b1011 held: zones 0, 1, 3, 0
        cyc(1);
        check("rr_start_estado", 32'(estado), 32'h1);
        check("rr_zona_a", 32'(zona_ativa), 32'h0);
        check("rr_start_bomba", 32'(bomba), 32'h1);
        cyc(20);
        check("rr_end_estado", 32'(estado), 32'h0);
        check("rr_end_fim", 32'(ciclo_fim), 32'h1);
        cyc(1);
        check("rr_zona_b", 32'(zona_ativa), 32'h1);
        check("rr_b_estado", 32'(estado), 32'h1);
        cyc(21);
        check("rr_zona_c", 32'(zona_ativa), 32'h3);
        cyc(21);
        check("rr_zona_d", 32'(zona_ativa), 32'h0);
        zona_req = 4'b0000;

        // BCD borrow on second instance (T_ENCH=00 behaves as 01, T_GOT=10)
        req_b = 2'b01;
        cyc(1);
        check("bcd_ench", 32'(estado_b), 32'h1);
        check("bcd_ench_digits", 32'({dezena_b, unidade_b}), 32'h01);
        req_b = 2'b00;
        cyc(2);
        check("bcd_got", 32'(estado_b), 32'h2);
        check("bcd_d10", 32'({dezena_b, unidade_b}), 32'h10);
        check("bcd_valvula", 32'(valvula_b), 32'h1);
        cyc(2);
        check("bcd_d09", 32'({dezena_b, unidade_b}), 32'h09);
        cyc(2);
        check("bcd_d08", 32'({dezena_b, unidade_b}), 32'h08);
        cyc(15);
        check("bcd_last", 32'(estado_b), 32'h2);
        check("bcd_last_d", 32'({dezena_b, unidade_b}), 32'h01);
        cyc(1);
        check("bcd_idle", 32'(estado_b), 32'h0);
        check("bcd_fim", 32'(ciclo_fim_b), 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irrigacao_multizona.md
# irrigacao_multizona

Parametrised multi-zone irrigation sequencer, successor to the single-zone fill/drip/spray/clean controller. It serves up to ZONES zone requests round-robin, running fill, then drip or spray for the selected zone, then clean after spray. Each phase is timed by an internal two-digit BCD seconds countdown derived from a clock prescaler. It sits between the zone request/mode switches and the valve and pump drivers. It also supplies BCD time digits and a one-hot state vector to the display multiplexer.

## Interface
- ZONES, 4: number of zones, 1..16; ZW = max(1, clog2(ZONES)).
- TICK_DIV, 50_000_000: clk1 cycles per 1 s tick, ≥2.
- T_ENCH, 8'h10: fill duration, 2-digit BCD seconds.
- T_GOT, 8'h30: drip duration, BCD.
- T_ASP, 8'h20: spray duration, BCD.
- T_LIMP, 8'h05: clean duration, BCD.
- clk1  in  1  system clock. One clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- zona_req  in  ZONES  level request per zone.
- zona_aspersao  in  ZONES  per-zone mode: 1 spray, 0 drip.
- pausa  in  1  freeze timing; force actuators off.
- agroDefensivo  in  1  agrochemical arm toggle, level, synchronous.
- bomba  out  1  fill pump; high in ENCHIMENTO and not pausa.
- valvula  out  ZONES  one-hot; the served zone's bit is high in GOTEJAMENTO/ASPERSAO and not pausa.
- estado  out  4  one-hot {LIMP,ASP,GOT,ENCH}; 0 in IDLE.
- zona_ativa  out  ZW  latched served zone index.
- unidade, dezena  out  4 each  BCD remaining seconds.
- ciclo_fim  out  1  one-cycle pulse on return to IDLE.
- saidaAgroDefensivo  out  1  agrochemical injector.

## Operation
- States: IDLE, ENCH, GOT, ASP, LIMP.
- Transitions:
  - IDLE→ENCH when any zona_req bit is set.
  - ENCH→ASP if the latched mode is 1, else ENCH→GOT.
  - GOT→IDLE.
  - ASP→LIMP.
  - LIMP→IDLE.
- Zone arbitration, on leaving IDLE:
  - Select the first set zona_req bit scanning upward from pointer ptr, wrapping at ZONES-1.
  - Latch the index into zona_ativa. Latch zona_aspersao[index] as the mode.
  - Later request and mode changes do not affect the running cycle.
- ptr update: set ptr = zona_ativa+1 mod ZONES on return to IDLE.
- Countdown loading:
  - On entering a phase, load {dezena,unidade} with that phase's duration. A duration of 00 is treated as 01.
  - In IDLE both digits read 0.
- Countdown stepping, on each tick:
  - Count 01: advance phase, loading the next phase's duration.
  - Otherwise: BCD decrement. Units 0 borrows, giving units 9 and tens−1.
  - Illegal BCD digits never occur.
- Prescaler:
  - Counts 0..TICK_DIV-1 and ticks on the wrap.
  - Cleared to 0 on IDLE→ENCH.
  - Not cleared between phases.
- pausa high:
  - Prescaler, countdown and FSM hold.
  - bomba, valvula and saidaAgroDefensivo are 0.
  - estado and digits stay visible.
  - In IDLE, pausa blocks the start of a cycle.
- ciclo_fim: asserted on the cycle after the IDLE entry edge, for exactly one cycle.
- Reset values: state IDLE, ptr 0, zona_ativa 0, all outputs 0, prescaler 0, armed flag 0. Reset mid-cycle aborts immediately and closes actuators asynchronously.

## Timing
- Each phase lasts exactly D×TICK_DIV clk1 cycles, plus any cycles with pausa high.
- The IDLE→ENCH decision is registered: bomba rises on the edge after zona_req is sampled set.
- Phase-to-phase switch is a single edge. The outgoing and incoming actuators never overlap, since all outputs are decoded from registered state.
- agroDefensivo is sampled through 2 synchronising flops. Its rising edge toggles the armed flag 3 cycles later.

## Configuration
- AGRO_DEFENSIVO_EN defined: saidaAgroDefensivo = armed & (state==ASP) & ~pausa. The armed flag persists across cycles.
- AGRO_DEFENSIVO_EN undefined: the synchronisers and armed flag are not built, agroDefensivo is ignored, and saidaAgroDefensivo is tied 0.
- Ports are identical in both builds.

## Test plan
- Drip cycle (ZONES=4, TICK_DIV=4, T_ENCH=02, T_GOT=03): zona_req=4'b0100, mode 0.
  - ENCH for 8 cycles with bomba=1 and digits 02→01.
  - GOT for 12 cycles with valvula=4'b0100.
  - Then IDLE with ciclo_fim one pulse and zona_ativa=2.
- Spray with agro (macro defined, T_ASP=02, T_LIMP=01): arm via one agroDefensivo pulse; zone 1, mode 1.
  - ENCH→ASP with saidaAgroDefensivo=1 only during ASP.
  - Then LIMP for 4 cycles, then IDLE.
- Round-robin: zona_req=4'b1011 held, three cycles → served zones 0, 1, 3, then 0 again.
- BCD borrow (T_GOT=10): digits step 10→09→08; phase ends after 10 ticks.
- pausa mid-GOT for 7 cycles: valvula drops to 0 and digits freeze. After release, the phase completes with total length 12+7 cycles.
- reset_n low mid-ASP:
  - All outputs drop to 0 within the same cycle, with no clock needed.
  - After release with zona_req still set, a fresh ENCH starts at the zone scan from ptr=0.
